// File: rtl/yazmac_yazma_hakemi.sv
// yazmac_yazma_hakemi: round-robin write-port arbiter and pending-write scoreboard for the register bank
//   clk_g, rst_n_g                      clock, asynchronous active-low reset
//   y0_* / y1_*                         writeback requesters (valid, address, data, accept)
//   hy_adres_c, hy_deger_c, yaz_c       registered write port to the register bank
//   rezerve_g, rezerve_adres_g          issue stage destination reservation
//   oku1_adres_g, oku2_adres_g          issue stage source registers
//   durdur_c                            hazard stall to the issue stage
//   bekleyen_c                          pending-write mask
module yazmac_yazma_hakemi #(
    parameter int HY_BIT   = 5,
    parameter int VERI_BIT = 32
) (
    input  logic                  clk_g,
    input  logic                  rst_n_g,
    input  logic                  y0_gecerli_g,
    input  logic [HY_BIT-1:0]     y0_adres_g,
    input  logic [VERI_BIT-1:0]   y0_deger_g,
    output logic                  y0_hazir_c,
    input  logic                  y1_gecerli_g,
    input  logic [HY_BIT-1:0]     y1_adres_g,
    input  logic [VERI_BIT-1:0]   y1_deger_g,
    output logic                  y1_hazir_c,
    output logic [HY_BIT-1:0]     hy_adres_c,
    output logic [VERI_BIT-1:0]   hy_deger_c,
    output logic                  yaz_c,
    input  logic                  rezerve_g,
    input  logic [HY_BIT-1:0]     rezerve_adres_g,
    input  logic [HY_BIT-1:0]     oku1_adres_g,
    input  logic [HY_BIT-1:0]     oku2_adres_g,
    output logic                  durdur_c,
    output logic [2**HY_BIT-1:0]  bekleyen_c
);
    localparam int HY_SAYI = 2**HY_BIT;
    localparam logic [HY_SAYI-1:0] BIR = 1;
    logic                oncelik;
    logic                kabul;
    logic                yazilir;
    logic [HY_BIT-1:0]   kaz_adres;
    logic [VERI_BIT-1:0] kaz_deger;
    logic [HY_SAYI-1:0]  temizle;
    logic [HY_SAYI-1:0]  koy;
    logic [HY_SAYI-1:0]  bek_sonraki;
    // oncelik=0 favours y0 on contention, oncelik=1 favours y1
    always_comb begin
        y0_hazir_c  = y0_gecerli_g & (~y1_gecerli_g | ~oncelik);
        y1_hazir_c  = y1_gecerli_g & (~y0_gecerli_g | oncelik);
        kabul       = y0_hazir_c | y1_hazir_c;
        kaz_adres   = y0_hazir_c ? y0_adres_g : y1_adres_g;
        kaz_deger   = y0_hazir_c ? y0_deger_g : y1_deger_g;
        yazilir     = kabul & (kaz_adres != '0);
        durdur_c    = bekleyen_c[oku1_adres_g] | bekleyen_c[oku2_adres_g]
                    | (rezerve_g & bekleyen_c[rezerve_adres_g]);
        // clear on the edge the bank captures; a same-edge reservation wins
        temizle     = yaz_c ? BIR << hy_adres_c : '0;
        koy         = (rezerve_g & ~durdur_c & (rezerve_adres_g != '0)) ? BIR << rezerve_adres_g : '0;
        bek_sonraki = ((bekleyen_c & ~temizle) | koy) & ~BIR;
    end
    always_ff @(posedge clk_g or negedge rst_n_g) begin
        if (!rst_n_g) begin
            oncelik    <= 1'b0;
            yaz_c      <= 1'b0;
            hy_adres_c <= '0;
            hy_deger_c <= '0;
            bekleyen_c <= '0;
        end else begin
            if (kabul) oncelik <= y0_hazir_c;
            yaz_c      <= yazilir;
            if (yazilir) begin
                hy_adres_c <= kaz_adres;
                hy_deger_c <= kaz_deger;
            end
            bekleyen_c <= bek_sonraki;
        end
    end
endmodule

// File: tb/tb_yazmac_yazma_hakemi.sv
// tb_yazmac_yazma_hakemi: directed and randomized checks of the write arbiter and hazard scoreboard
module tb_yazmac_yazma_hakemi;
    logic        clk_g = 1'b0;
    logic        rst_n_g = 1'b0;
    logic        y0_gecerli_g = 1'b0, y1_gecerli_g = 1'b0;
    logic [4:0]  y0_adres_g = '0, y1_adres_g = '0;
    logic [31:0] y0_deger_g = '0, y1_deger_g = '0;
    logic        y0_hazir_c, y1_hazir_c, yaz_c, durdur_c;
    logic [4:0]  hy_adres_c;
    logic [31:0] hy_deger_c;
    logic        rezerve_g = 1'b0;
    logic [4:0]  rezerve_adres_g = '0, oku1_adres_g = '0, oku2_adres_g = '0;
    logic [31:0] bekleyen_c;

    yazmac_yazma_hakemi dut (
        .clk_g(clk_g), .rst_n_g(rst_n_g),
        .y0_gecerli_g(y0_gecerli_g), .y0_adres_g(y0_adres_g), .y0_deger_g(y0_deger_g), .y0_hazir_c(y0_hazir_c),
        .y1_gecerli_g(y1_gecerli_g), .y1_adres_g(y1_adres_g), .y1_deger_g(y1_deger_g), .y1_hazir_c(y1_hazir_c),
        .hy_adres_c(hy_adres_c), .hy_deger_c(hy_deger_c), .yaz_c(yaz_c),
        .rezerve_g(rezerve_g), .rezerve_adres_g(rezerve_adres_g),
        .oku1_adres_g(oku1_adres_g), .oku2_adres_g(oku2_adres_g),
        .durdur_c(durdur_c), .bekleyen_c(bekleyen_c)
    );

    always #5 clk_g = ~clk_g;

    int total = 0, bad = 0;
    bit chk_on = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // reference model: who was last served, what the bank is being told to write, which registers await a write
    int          m_onc, w;
    bit          m_yaz, st;
    logic [4:0]  m_adr, wa;
    logic [31:0] m_dat, wd, pv;
    bit          pend [32];

    always @(negedge clk_g) begin
        if (!rst_n_g) begin
            m_onc = 0; m_yaz = 0; m_adr = '0; m_dat = '0;
            foreach (pend[i]) pend[i] = 0;
        end else if (chk_on) begin
            w  = (y0_gecerli_g && y1_gecerli_g) ? m_onc : y0_gecerli_g ? 0 : y1_gecerli_g ? 1 : -1;
            st = pend[oku1_adres_g] || pend[oku2_adres_g] || (rezerve_g && pend[rezerve_adres_g]);
            foreach (pend[i]) pv[i] = pend[i];
            chk("y0_hazir", y0_hazir_c, w == 0);
            chk("y1_hazir", y1_hazir_c, w == 1);
            chk("durdur", durdur_c, st);
            chk("yaz", yaz_c, m_yaz);
            chk("bekleyen", bekleyen_c, pv);
            if (m_yaz) begin
                chk("hy_adres", hy_adres_c, m_adr);
                chk("hy_deger", hy_deger_c, m_dat);
                pend[m_adr] = 0;
            end
            if (rezerve_g && !st && rezerve_adres_g != 0) pend[rezerve_adres_g] = 1;
            wa = (w == 0) ? y0_adres_g : y1_adres_g;
            wd = (w == 0) ? y0_deger_g : y1_deger_g;
            m_yaz = (w >= 0) && (wa != 0);
            if (m_yaz) begin m_adr = wa; m_dat = wd; end
            if (w >= 0) m_onc = 1 - w;
        end
    end

    task automatic step();
        @(posedge clk_g);
        #1;
    endtask

    task automatic do_reset();
        chk_on = 0;
        rst_n_g = 0;
        y0_gecerli_g = 0; y1_gecerli_g = 0; rezerve_g = 0;
        rezerve_adres_g = 0; oku1_adres_g = 0; oku2_adres_g = 0;
        @(negedge clk_g);
        @(posedge clk_g);
        #1 rst_n_g = 1;
        chk("rst yaz", yaz_c, 0);
        chk("rst hy_adres", hy_adres_c, 0);
        chk("rst hy_deger", hy_deger_c, 0);
        chk("rst bekleyen", bekleyen_c, 0);
        chk_on = 1;
    endtask

    bit a0, a1;

    initial begin
        do_reset();
        // single requester, write visible one edge later for one cycle
        y0_gecerli_g = 1; y0_adres_g = 5; y0_deger_g = 32'hDEADBEEF;
        #1 chk("t1 hazir", y0_hazir_c, 1);
        step();
        y0_gecerli_g = 0;
        chk("t1 yaz", yaz_c, 1);
        chk("t1 adres", hy_adres_c, 5);
        chk("t1 deger", hy_deger_c, 32'hDEADBEEF);
        step();
        chk("t1 yaz low", yaz_c, 0);
        // contention alternates starting with y0
        do_reset();
        y0_gecerli_g = 1; y0_adres_g = 1; y0_deger_g = 32'hA1;
        y1_gecerli_g = 1; y1_adres_g = 2; y1_deger_g = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2 y0_hazir", y0_hazir_c, (i % 2) == 0);
            chk("t2 y1_hazir", y1_hazir_c, (i % 2) == 1);
            step();
            chk("t2 yaz", yaz_c, 1);
            chk("t2 adres", hy_adres_c, (i % 2) == 0 ? 1 : 2);
        end
        y0_gecerli_g = 0; y1_gecerli_g = 0;
        // RAW stall released when the write lands
        rezerve_g = 1; rezerve_adres_g = 7;
        #1 chk("t3 durdur0", durdur_c, 0);
        step();
        rezerve_g = 0; oku1_adres_g = 7;
        #1 chk("t3 durdur1", durdur_c, 1);
        chk("t3 bek", bekleyen_c, 32'h80);
        y1_gecerli_g = 1; y1_adres_g = 7; y1_deger_g = 32'h77;
        #1 chk("t3 y1_hazir", y1_hazir_c, 1);
        step();
        y1_gecerli_g = 0;
        chk("t3 yaz", yaz_c, 1);
        chk("t3 adres", hy_adres_c, 7);
        #1 chk("t3 durdur still", durdur_c, 1);
        step();
        chk("t3 bek clr", bekleyen_c, 0);
        chk("t3 durdur off", durdur_c, 0);
        oku1_adres_g = 0;
        // x0 writes and reservations are discarded
        y0_gecerli_g = 1; y0_adres_g = 0; y0_deger_g = 32'h1234;
        #1 chk("t4 hazir", y0_hazir_c, 1);
        step();
        y0_gecerli_g = 0;
        chk("t4 yaz", yaz_c, 0);
        rezerve_g = 1; rezerve_adres_g = 0;
        #1 chk("t4 durdur", durdur_c, 0);
        step();
        rezerve_g = 0;
        chk("t4 bek", bekleyen_c, 0);
        // clear against an ignored reservation, then set winning over clear
        rezerve_g = 1; rezerve_adres_g = 9;
        step();
        rezerve_g = 0;
        chk("t5 bek set", bekleyen_c, 32'h200);
        y0_gecerli_g = 1; y0_adres_g = 9; y0_deger_g = 32'h99;
        step();
        y0_gecerli_g = 0;
        chk("t5 yaz", yaz_c, 1);
        rezerve_g = 1; rezerve_adres_g = 9;
        #1 chk("t5 durdur", durdur_c, 1);
        step();
        rezerve_g = 0;
        chk("t5 bek clr", bekleyen_c, 0);
        y0_gecerli_g = 1;
        step();
        y0_gecerli_g = 0;
        rezerve_g = 1;
        #1 chk("t5 durdur fresh", durdur_c, 0);
        step();
        rezerve_g = 0;
        chk("t5 set wins", bekleyen_c, 32'h200);
        y0_gecerli_g = 1;
        step();
        y0_gecerli_g = 0;
        step();
        chk("t5 cleanup", bekleyen_c, 0);
        // asynchronous reset in mid-cycle
        rezerve_g = 1; rezerve_adres_g = 7;
        step();
        rezerve_adres_g = 10;
        step();
        rezerve_g = 0;
        y0_gecerli_g = 1; y0_adres_g = 3; y0_deger_g = 32'h33;
        step();
        y0_gecerli_g = 0;
        chk("t6 bek", bekleyen_c, 32'h480);
        chk("t6 yaz", yaz_c, 1);
        #2 chk_on = 0;
        rst_n_g = 0;
        #1;
        chk("t6 yaz", yaz_c, 0);
        chk("t6 adres", hy_adres_c, 0);
        chk("t6 deger", hy_deger_c, 0);
        chk("t6 bek", bekleyen_c, 0);
        do_reset();
        // random traffic; an unaccepted requester holds its request
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_g);
            a0 = y0_hazir_c; a1 = y1_hazir_c;
            step();
            if (!y0_gecerli_g || a0) begin
                y0_gecerli_g = $urandom_range(0, 9) < 6;
                y0_adres_g = 5'($urandom_range(0, 15));
                y0_deger_g = $urandom;
            end
            if (!y1_gecerli_g || a1) begin
                y1_gecerli_g = $urandom_range(0, 9) < 6;
                y1_adres_g = 5'($urandom_range(0, 15));
                y1_deger_g = $urandom;
            end
            rezerve_g = $urandom_range(0, 9) < 3;
            rezerve_adres_g = 5'($urandom_range(0, 15));
            oku1_adres_g = 5'($urandom_range(0, 15));
            oku2_adres_g = 5'($urandom_range(0, 15));
        end
        @(negedge clk_g);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
